// File: rtl/lap_stopwatch.sv
// BCD up/down stopwatch with per-digit mod-6/mod-10 digits, wrap or saturate limits,
// clear/load, and a lap register that freezes the display while counting continues.
module lap_stopwatch #(
  parameter int                DIGITS    = 4,
  parameter int                TICK_DIV  = 1,
  parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'(4'b0010),
  parameter int                WRAP      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  input  logic                  lap_release,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  lap_active,
  output logic                  tick,
  output logic                  tc
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  function automatic logic [3:0] digit_max(input int i);
    return MOD6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] full_val();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = digit_max(i);
    return v;
  endfunction

  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Out-of-range load digits (including non-BCD codes) pin to that digit's maximum.
  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (r[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    return r;
  endfunction

  logic [PW-1:0] presc;
  logic [W-1:0]  lap_val;
  logic [W-1:0]  full_v;
  logic [W-1:0]  step_val;
  logic          step_tc;

  assign full_v  = full_val();
  assign tick    = enable && (presc == PMAX);
  assign display = lap_active ? lap_val : count;

  // Next count for a tick step, including limit handling.
  always_comb begin
    step_val = count;
    step_tc  = 1'b0;
    if (up) begin
      if (count == full_v) begin
        step_val = (WRAP != 0) ? '0 : count;
        step_tc  = 1'b1;
      end else begin
        step_val = step_up(count);
      end
    end else begin
      if (count == '0) begin
        step_val = (WRAP != 0) ? full_v : count;
        step_tc  = 1'b1;
      end else begin
        step_val = step_down(count);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      presc      <= '0;
      lap_val    <= '0;
      lap_active <= 1'b0;
      tc         <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      presc      <= '0;
      lap_val    <= '0;
      lap_active <= 1'b0;
      tc         <= 1'b0;
    end else begin
      if (load) begin
        count <= clamp_load(load_val);
        presc <= '0;
        tc    <= 1'b0;
      end else if (tick) begin
        count <= step_val;
        presc <= '0;
        tc    <= step_tc;
      end else begin
        tc <= 1'b0;
        if (enable) presc <= presc + 1'b1;
      end
      // Lap captures the pre-edge count; a lap request beats a simultaneous release.
      if (lap) begin
        lap_val    <= count;
        lap_active <= 1'b1;
      end else if (lap_release) begin
        lap_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: three instances (default, saturating, TICK_DIV=4) share stimulus.
module tb_lap_stopwatch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
  logic        lap = 1'b0, lap_release = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] cnt_o  [3];
  logic [15:0] disp_o [3];
  logic        la_o   [3];
  logic        tick_o [3];
  logic        tc_o   [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lap_stopwatch u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .lap(lap), .lap_release(lap_release), .count(cnt_o[0]),
    .display(disp_o[0]), .lap_active(la_o[0]), .tick(tick_o[0]), .tc(tc_o[0]));

  lap_stopwatch #(.WRAP(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .lap(lap), .lap_release(lap_release), .count(cnt_o[1]),
    .display(disp_o[1]), .lap_active(la_o[1]), .tick(tick_o[1]), .tc(tc_o[1]));

  lap_stopwatch #(.TICK_DIV(4)) u_div (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .lap(lap), .lap_release(lap_release), .count(cnt_o[2]),
    .display(disp_o[2]), .lap_active(la_o[2]), .tick(tick_o[2]), .tc(tc_o[2]));

  typedef struct {
    int          sel;
    logic        clr, ld;
    logic [15:0] lv;
    logic        en, dir, lp, rel;
    logic [15:0] ecnt, edisp;
    logic        ela, etc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic clr, input logic ld, input logic [15:0] lv,
                     input logic en, input logic dir, input logic lp, input logic rel,
                     input logic [15:0] ec, input logic [15:0] ed, input logic ela,
                     input logic etc);
    vec_t v;
    v.sel = sel; v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.dir = dir;
    v.lp = lp; v.rel = rel; v.ecnt = ec; v.edisp = ed; v.ela = ela; v.etc = etc;
    tbl.push_back(v);
  endtask

  // Drive one vector at the falling edge, then compare after the next rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    clear = v.clr; load = v.ld; load_val = v.lv; enable = v.en; up = v.dir;
    lap = v.lp; lap_release = v.rel;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("row%0d scoreboard", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("row%0d count", idx),      32'(cnt_o[e.sel]),  32'(e.ecnt));
      chk($sformatf("row%0d display", idx),    32'(disp_o[e.sel]), 32'(e.edisp));
      chk($sformatf("row%0d lap_active", idx), 32'(la_o[e.sel]),   32'(e.ela));
      chk($sformatf("row%0d tc", idx),         32'(tc_o[e.sel]),   32'(e.etc));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Count from reset: 1..9 then 0x0010, tc never high.
    for (int k = 1; k <= 10; k++)
      add(0, 0, 0, 16'h0, 1, 1, 0, 0, (k < 10) ? 16'(k) : 16'h0010,
          (k < 10) ? 16'(k) : 16'h0010, 0, 0);
    // Mod-6 carry and borrow.
    add(0, 0, 1, 16'h0059, 0, 0, 0, 0, 16'h0059, 16'h0059, 0, 0);
    add(0, 0, 0, 16'h0,    1, 1, 0, 0, 16'h0100, 16'h0100, 0, 0);
    add(0, 0, 1, 16'h0100, 0, 0, 0, 0, 16'h0100, 16'h0100, 0, 0);
    add(0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0059, 16'h0059, 0, 0);
    // Wrapping limits.
    add(0, 0, 1, 16'h9959, 0, 0, 0, 0, 16'h9959, 16'h9959, 0, 0);
    add(0, 0, 0, 16'h0,    1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h9959, 16'h9959, 0, 1);
    add(0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h9959, 16'h9959, 0, 0);
    // Saturating limits on the WRAP=0 instance.
    add(1, 0, 1, 16'h9959, 0, 0, 0, 0, 16'h9959, 16'h9959, 0, 0);
    add(1, 0, 0, 16'h0,    1, 1, 0, 0, 16'h9959, 16'h9959, 0, 1);
    add(1, 0, 0, 16'h0,    0, 0, 0, 0, 16'h9959, 16'h9959, 0, 0);
    add(1, 0, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    add(1, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    // Lap, split and release.
    add(0, 0, 1, 16'h0012, 0, 0, 0, 0, 16'h0012, 16'h0012, 0, 0);
    add(0, 0, 0, 16'h0,    0, 0, 1, 0, 16'h0012, 16'h0012, 1, 0);
    for (int j = 1; j <= 5; j++)
      add(0, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0012 + 16'(j), 16'h0012, 1, 0);
    add(0, 0, 0, 16'h0,    0, 0, 1, 0, 16'h0017, 16'h0017, 1, 0);
    add(0, 0, 0, 16'h0,    0, 0, 0, 1, 16'h0017, 16'h0017, 0, 0);
    add(0, 0, 0, 16'h0,    1, 1, 0, 0, 16'h0018, 16'h0018, 0, 0);
    add(0, 0, 0, 16'h0,    0, 0, 1, 0, 16'h0018, 16'h0018, 1, 0);
    // Priority: clear beats load, tick and lap; load beats tick; clamp.
    add(0, 1, 1, 16'h1234, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 0, 16'h0,    0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 1, 16'h7A9F, 1, 1, 0, 0, 16'h7959, 16'h7959, 0, 0);
    for (int j = 0; j < 20; j++)
      add(0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h7959, 16'h7959, 0, 0);
    // lap with lap_release: lap wins; full carry chain while frozen.
    add(0, 0, 0, 16'h0,    0, 0, 1, 1, 16'h7959, 16'h7959, 1, 0);
    add(0, 0, 0, 16'h0,    1, 1, 0, 0, 16'h8000, 16'h7959, 1, 0);
    add(0, 0, 0, 16'h0,    0, 0, 0, 1, 16'h8000, 16'h8000, 0, 0);
    add(0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h7959, 16'h7959, 0, 0);

    // Asynchronous reset, asserted between edges.
    #2 reset_n = 1'b0;
    #10;
    chk("reset count",      32'(cnt_o[0]),  32'h0);
    chk("reset display",    32'(disp_o[0]), 32'h0);
    chk("reset lap_active", 32'(la_o[0]),   32'h0);
    chk("reset tc",         32'(tc_o[0]),   32'h0);
    chk("reset tick",       32'(tick_o[0]), 32'h0);
    chk("reset div count",  32'(cnt_o[2]),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Prescaler, TICK_DIV=4: ticks on enabled cycles 4, 8, 12.
    clear = 1'b1; enable = 1'b0; load = 1'b0; lap = 1'b0; lap_release = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      enable = 1'b1; up = 1'b1;
      #1;
      chk($sformatf("div tick c%0d", k), 32'(tick_o[2]), (k % 4 == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk($sformatf("div count c%0d", k), 32'(cnt_o[2]), 32'(k / 4));
      @(negedge clk);
    end

    // Disabled cycles stretch the interval without resetting the prescaler.
    enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; @(negedge clk); end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lap = (k == 0);
      #1;
      chk("div stall tick", 32'(tick_o[2]), 32'd0);
      @(posedge clk); #1;
      chk("div stall count", 32'(cnt_o[2]), 32'd3);
      @(negedge clk);
    end
    lap = 1'b0;
    enable = 1'b1;
    #1;
    chk("div resume tick early", 32'(tick_o[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    #1;
    chk("div resume tick", 32'(tick_o[2]), 32'd1);
    @(posedge clk); #1;
    chk("div resume count", 32'(cnt_o[2]), 32'd4);
    chk("div lap held", 32'(la_o[2]), 32'd1);
    @(negedge clk);

    // Reset mid-count and mid-lap, between edges.
    @(posedge clk); #1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset div count",      32'(cnt_o[2]),  32'h0);
    chk("midreset div lap_active", 32'(la_o[2]),   32'h0);
    chk("midreset div display",    32'(disp_o[2]), 32'h0);
    chk("midreset count",          32'(cnt_o[0]),  32'h0);
    @(negedge clk);
    reset_n = 1'b1; enable = 1'b1; up = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset div count c%0d", k), 32'(cnt_o[2]), (k == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
